// File: rtl/sr_scan_ctrl.sv
// sr_scan_ctrl -- scan controller for an 8-digit multiplexed 7-segment display
// driven through a 16-bit 74HC595-style shift-register chain.
//
// Each digit becomes a frame {segment byte, digit-select byte}. The frame is
// shifted out MSB-first on sclk_o/dio_o and latched with an rclk_o pulse. The
// digit is then held for DWELL cycles before the next one is sent.
//
// Ports:
//   clk           system clock, everything on posedge
//   rst_n_i       synchronous active-low reset
//   en_i          scan enable (level)
//   value_i[31:0] hex digits, digit k = value_i[4k+3:4k]
//   dp_i[7:0]     decimal point per digit (active-high)
//   digit_en_i    per-digit enable, 0 blanks the digit (still scanned)
//   sclk_o        shift clock to chain
//   dio_o         serial data to chain
//   rclk_o        storage-register latch pulse
//   busy_o        high whenever not IDLE
//   cur_digit_o   digit being sent / displayed
//   frame_done_o  one-cycle pulse when digit 7's dwell ends
module sr_scan_ctrl #(
  parameter int unsigned CLK_DIV        = 2,
  parameter int unsigned DWELL          = 1000,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          SEL_ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n_i,
  input  logic        en_i,
  input  logic [31:0] value_i,
  input  logic [7:0]  dp_i,
  input  logic [7:0]  digit_en_i,
  output logic        sclk_o,
  output logic        dio_o,
  output logic        rclk_o,
  output logic        busy_o,
  output logic [2:0]  cur_digit_o,
  output logic        frame_done_o
);

  // One counter serves the bit period, latch pulse and dwell; size it for the longest.
  localparam int unsigned BIT_CYC = 2 * CLK_DIV;
  localparam int unsigned MAXC    = (BIT_CYC > DWELL) ? BIT_CYC : DWELL;
  localparam int unsigned CW      = $clog2(MAXC);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SHIFT, S_LATCH, S_DWELL} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    bit_q, bit_d;
  logic [15:0]   sh_q, sh_d;
  logic [2:0]    dig_q, dig_d;
  logic [31:0]   val_q, val_d;
  logic [7:0]    dp_q, dp_d, den_q, den_d;
  logic          fd_q, fd_d;
  logic          capture;
  logic [7:0]    seg, seg_x, sel_x;
  logic [15:0]   frame;

  function automatic logic [6:0] hex7(input logic [3:0] h);
    case (h)
      4'h0: hex7 = 7'h3F; 4'h1: hex7 = 7'h06; 4'h2: hex7 = 7'h5B; 4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66; 4'h5: hex7 = 7'h6D; 4'h6: hex7 = 7'h7D; 4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F; 4'h9: hex7 = 7'h6F; 4'hA: hex7 = 7'h77; 4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39; 4'hD: hex7 = 7'h5E; 4'hE: hex7 = 7'h79; default: hex7 = 7'h71;
    endcase
  endfunction

  // Frame is built from the shadow registers only, so a pass never tears.
  always_comb begin
    seg   = den_q[dig_q] ? {dp_q[dig_q], hex7(val_q[{dig_q, 2'b00} +: 4])} : 8'h00;
    seg_x = SEG_ACTIVE_LOW ? ~seg : seg;
    sel_x = SEL_ACTIVE_LOW ? ~(8'h01 << dig_q) : (8'h01 << dig_q);
    frame = {seg_x, sel_x};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    dig_d   = dig_q;
    fd_d    = 1'b0;
    capture = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        dig_d = '0;
        if (en_i) begin
          state_d = S_LOAD;
          capture = 1'b1;
        end
      end
      S_LOAD: begin
        sh_d    = frame;
        cnt_d   = '0;
        bit_d   = '0;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        // Low for CLK_DIV, high for CLK_DIV; the shift lands with the falling edge.
        if (cnt_q == CW'(BIT_CYC - 1)) begin
          cnt_d = '0;
          sh_d  = {sh_q[14:0], 1'b0};
          if (bit_q == 4'd15) state_d = S_LATCH;
          else                bit_d   = bit_q + 4'd1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_LATCH: begin
        if (cnt_q == CW'(CLK_DIV - 1)) begin
          cnt_d   = '0;
          state_d = S_DWELL;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DWELL: begin
        if (cnt_q == CW'(DWELL - 1)) begin
          cnt_d = '0;
          fd_d  = (dig_q == 3'd7);
          if (en_i) begin
            dig_d   = dig_q + 3'd1;
            state_d = S_LOAD;
            capture = (dig_q == 3'd7);
          end else begin
            dig_d   = '0;
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    val_d = capture ? value_i    : val_q;
    dp_d  = capture ? dp_i       : dp_q;
    den_d = capture ? digit_en_i : den_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      dig_q   <= '0;
      val_q   <= '0;
      dp_q    <= '0;
      den_q   <= '0;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      dig_q   <= dig_d;
      val_q   <= val_d;
      dp_q    <= dp_d;
      den_q   <= den_d;
      fd_q    <= fd_d;
    end
  end

  // Pin outputs decode straight from registered state, so sclk and rclk cannot overlap.
  assign sclk_o       = (state_q == S_SHIFT) && (cnt_q >= CW'(CLK_DIV));
  assign dio_o        = (state_q == S_SHIFT) && sh_q[15];
  assign rclk_o       = (state_q == S_LATCH);
  assign busy_o       = (state_q != S_IDLE);
  assign cur_digit_o  = dig_q;
  assign frame_done_o = fd_q;

endmodule

// File: doc/sr_scan_ctrl.md
# sr_scan_ctrl

Scan controller for an 8-digit multiplexed 7-segment display behind a 16-bit 74HC595-style shift-register chain. Decodes a 32-bit hex value into per-digit frames {segment byte, digit-select byte} and shifts each frame out MSB-first on sclk/dio. It then pulses rclk and holds each digit for a programmable dwell time. Sits between CPU-visible display registers and the board's shift-register pins.

## Interface
- CLK_DIV, 2: clk cycles per sclk half-period; ≥1.
- DWELL, 1000: clk cycles each digit stays latched before the next frame; ≥1.
- SEG_ACTIVE_LOW, 1: 1 = segment byte inverted before shifting.
- SEL_ACTIVE_LOW, 1: 1 = digit-select byte inverted before shifting.
- clk  in  1  system clock; all logic on posedge.
- rst_n_i  in  1  reset, synchronous, active-low.
- en_i  in  1  scanning enable (level).
- value_i  in  32  hex digits; digit k = value_i[4k+3:4k].
- dp_i  in  8  decimal point per digit, active-high.
- digit_en_i  in  8  per-digit enable; 0 blanks the digit.
- sclk_o  out  1  shift clock to chain.
- dio_o  out  1  serial data to chain.
- rclk_o  out  1  storage-register latch pulse.
- busy_o  out  1  high in every state except IDLE.
- cur_digit_o  out  3  digit currently being sent or displayed.
- frame_done_o  out  1  one-cycle pulse when digit 7's dwell ends.

## Operation
- States: IDLE, LOAD, SHIFT, LATCH, DWELL.
- IDLE: outputs low, cur_digit_o=0. en_i=1 → LOAD, snapshotting value_i, dp_i, digit_en_i into shadow registers.
- Shadow capture also occurs on every wrap from digit 7 to digit 0. No tearing within a pass.
- LOAD (1 cycle): build frame[15:0] = {seg, sel} for cur_digit_o into shift register, set dio_o=frame[15], then go to SHIFT.
- seg = {dp, g..a}. Active-high hex codes 0..F: 3F 06 5B 4F 66 6D 7D 07 7F 6F 77 7C 39 5E 79 71. dp sets bit 7.
- digit_en=0 → seg = 0x00 before polarity. The digit is still scanned, so duty cycle is constant.
- sel = one-hot, bit k for digit k.
- SEG_ACTIVE_LOW / SEL_ACTIVE_LOW invert the respective byte.
- SHIFT: per bit, sclk_o low CLK_DIV cycles, then high CLK_DIV cycles. On the last high cycle, shift the register left, present the next bit on dio_o and lower sclk_o. After the 16th bit → LATCH.
- LATCH: rclk_o high CLK_DIV cycles, then → DWELL.
- DWELL: DWELL cycles, then:
  - en_i=1: cur_digit_o+1 (7 wraps to 0 with frame_done_o pulse and shadow capture) → LOAD.
  - en_i=0: → IDLE; frame_done_o still pulses if digit was 7.
- en_i drop mid-digit: the current digit completes through DWELL, then IDLE.
- Input changes outside shadow capture have no effect on the pass in progress.

## Timing
- Reset (rst_n_i=0 at a posedge): state IDLE; sclk_o, dio_o, rclk_o, busy_o, frame_done_o = 0; cur_digit_o=0; shift register cleared.
- Reset mid-SHIFT abandons the frame with no rclk pulse, so the chain's output latch keeps the previous digit.
- en_i sampled in IDLE → busy_o high next cycle.
- Digit period = 1 + 32·CLK_DIV + CLK_DIV + DWELL cycles (1067 at defaults). Full pass = 8× that.
- dio_o is stable for all CLK_DIV cycles before each sclk_o rising edge and during the high phase.
- sclk_o and rclk_o are never high simultaneously.
- sclk_o is low in LOAD, LATCH, DWELL and IDLE.

## Test plan
- Reset: hold rst_n_i=0 for 3 clk with en_i=1 → all outputs 0, busy_o=0. Release → LOAD next cycle, busy_o=1.
- Defaults, value_i=0, dp_i=0, digit_en_i=FF: digit 0 sampled bits on sclk_o rises = 0xC0FE. rclk_o high 2 cycles after the 16th fall. Next LOAD exactly 1067 cycles after the first.
- SEG_ACTIVE_LOW=0, SEL_ACTIVE_LOW=0, value_i=0x89ABCDEF, dp_i=0x01: frames digits 0..7 = 0xF101 0x7902 0x5E04 0x3908 0x7C10 0x7720 0x6F40 0x7F80. frame_done_o pulses once after the digit-7 dwell.
- digit_en_i=0xFE, same value, active-high params: digit 0 frame = 0x0001. Digit 1 is unaffected. Period is unchanged.
- Change value_i mid-pass → remaining digits of that pass use the old value; the next pass uses the new value.
- Drop en_i during digit 3 SHIFT → digit 3 latches and dwells, then IDLE with cur_digit_o=0. Assert rst_n_i=0 mid-SHIFT on the next run → no rclk_o pulse, outputs 0 next cycle.
